pix_feeder: RTL and testbench

PIX_FEEDER -- requirements
Module: pix_feeder

---
 rtl/pix_feeder_if.sv | 23 ++
 rtl/pix_feeder.sv | 76 +++++++
 tb/tb_pix_feeder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pix_feeder_if.sv
// pix_feeder_if: upstream pixel stream plus consumer request/response bundle.
interface pix_feeder_if #(
    parameter int IN_W = 32
);
    logic [IN_W-1:0] s_data;
    logic            s_valid;
    logic            s_accept;
    logic            start;
    logic            request;
    logic            ready;
    logic [IN_W-1:0] o_data;
    logic            busy;
    logic            frame_done;
    logic            err_req;
    modport master (
        output s_data, s_valid, start, request,
        input  s_accept, ready, o_data, busy, frame_done, err_req
    );
    modport slave (
        input  s_data, s_valid, start, request,
        output s_accept, ready, o_data, busy, frame_done, err_req
    );
endinterface

// File: rtl/pix_feeder.sv
// pix_feeder: word FIFO that serves one packed pixel word per consumer request
// while a frame of FRM_WORDS words is running.
module pix_feeder #(
    parameter int PIX_W     = 8,
    parameter int IN_W      = PIX_W * 4,
    parameter int DEPTH     = 16,
    parameter int FRM_WORDS = 3840
) (
    input logic        clk,
    input logic        rst,
    pix_feeder_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(FRM_WORDS + 1);
    localparam logic [AW:0]    FULL = (AW + 1)'(DEPTH);
    localparam logic [WCW-1:0] LAST = WCW'(FRM_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [IN_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic [WCW-1:0]  r_wcnt;
    logic            r_pending, r_ready, r_err;
    logic [IN_W-1:0] r_odata;
    logic            w_run, w_push, w_pop, w_req;

    assign w_run  = r_state == RUN;
    assign w_push = bus.s_valid && bus.s_accept;
    assign w_req  = bus.request && w_run;
    // Pops stop once the frame's quota is drawn so a late request cannot leak a word into DONE.
    assign w_pop  = w_run && r_pending && r_count != '0 && r_wcnt < LAST;

    assign bus.s_accept   = r_count < FULL;
    assign bus.ready      = r_ready;
    assign bus.o_data     = r_odata;
    assign bus.busy       = w_run;
    assign bus.frame_done = r_state == DONE;
    assign bus.err_req    = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
                      (r_state == RUN)  ? ((r_ready && r_wcnt == LAST) ? DONE : RUN) :
                                          IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wcnt    <= '0;
            r_pending <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_odata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wptr    <= r_wptr + AW'(w_push);
            r_rptr    <= r_rptr + AW'(w_pop);
            r_count   <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            r_wcnt    <= (r_state == IDLE && bus.start) ? '0 : r_wcnt + WCW'(w_pop);
            r_pending <= w_req || (r_pending && !w_pop);
            r_err     <= r_err || (w_req && r_pending && !w_pop);
            r_ready   <= w_pop;
            if (w_pop) r_odata <= r_mem[r_rptr];
        end
    end
endmodule

// File: tb/tb_pix_feeder.sv
// tb_pix_feeder: directed vector table plus hand sequences for full/empty FIFO,
// lost request and mid-frame reset.
module tb_pix_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    pix_feeder_if #(.IN_W(32)) bus ();

    pix_feeder #(.PIX_W(8), .IN_W(32), .DEPTH(16), .FRM_WORDS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        st;
        logic        rq;
        logic        e_rdy;
        logic [31:0] e_od;
        logic        e_acc;
        logic        e_busy;
        logic        e_fd;
        logic        e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.start   = 1'b0;
        bus.request = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ready"}, 32'(bus.ready), 0);
        chk({nm, "_odata"}, bus.o_data, 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_fdone"}, 32'(bus.frame_done), 0);
        chk({nm, "_err"}, 32'(bus.err_req), 0);
        chk({nm, "_accept"}, 32'(bus.s_accept), 1);
    endtask

    initial begin
        int          nrdy;
        logic [31:0] got;
        tbl[0]  = '{1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h55667788, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h000000AA, 1'b0, 1'b1, 1'b0, 32'h55667788, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h000000AA, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h000000BB, 1'b0, 1'b1, 1'b0, 32'h000000AA, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h000000BB, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h000000BB, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h000000BB, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h000000BB, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h000000BB, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state, then delivery latency and frame end from the table
        do_reset();
        chk_reset_outs("rst0");
        for (int i = 0; i < 15; i++) begin
            bus.s_valid = tbl[i].v;
            bus.s_data  = tbl[i].d;
            bus.start   = tbl[i].st;
            bus.request = tbl[i].rq;
            tick();
            bus.s_valid = 1'b0;
            bus.start   = 1'b0;
            bus.request = 1'b0;
            chk($sformatf("v%0d_ready", i), 32'(bus.ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_odata", i), bus.o_data, tbl[i].e_od);
            chk($sformatf("v%0d_accept", i), 32'(bus.s_accept), 32'(tbl[i].e_acc));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_fdone", i), 32'(bus.frame_done), 32'(tbl[i].e_fd));
            chk($sformatf("v%0d_err", i), 32'(bus.err_req), 32'(tbl[i].e_err));
        end

        // Full FIFO: 16 words fill it, the 17th waits for a pop
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h100 + k;
            tick();
            chk($sformatf("full_acc%0d", k), 32'(bus.s_accept), (k < 15) ? 1 : 0);
        end
        bus.s_data = 32'h117;
        tick();
        chk("full_hold", 32'(bus.s_accept), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("full_run_acc", 32'(bus.s_accept), 0);
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        chk("full_pend_acc", 32'(bus.s_accept), 0);
        tick();
        chk("full_pop_ready", 32'(bus.ready), 1);
        chk("full_pop_data", bus.o_data, 32'h100);
        chk("full_pop_acc", 32'(bus.s_accept), 1);
        tick();
        bus.s_valid = 1'b0;
        chk("full_17th_in", 32'(bus.s_accept), 0);
        chk("full_err", 32'(bus.err_req), 0);

        // Empty FIFO: request waits for data, single ready two cycles after the push
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        nrdy = 0;
        repeat (4) begin
            tick();
            nrdy += int'(bus.ready);
        end
        chk("empty_no_early", 32'(nrdy), 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hBEEF0005;
        tick();
        bus.s_valid = 1'b0;
        chk("empty_p1_ready", 32'(bus.ready), 0);
        tick();
        chk("empty_p2_ready", 32'(bus.ready), 1);
        chk("empty_p2_data", bus.o_data, 32'hBEEF0005);
        nrdy = 0;
        repeat (4) begin
            tick();
            nrdy += int'(bus.ready);
        end
        chk("empty_once", 32'(nrdy), 0);
        chk("empty_hold", bus.o_data, 32'hBEEF0005);
        chk("empty_err", 32'(bus.err_req), 0);

        // Lost request: second request while still pending on an empty FIFO
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        tick();
        chk("lost_err_pre", 32'(bus.err_req), 0);
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        chk("lost_err_set", 32'(bus.err_req), 1);
        tick();
        chk("lost_err_sticky", 32'(bus.err_req), 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hC0DE0003;
        tick();
        bus.s_valid = 1'b0;
        nrdy = 0;
        got  = '0;
        repeat (6) begin
            tick();
            if (bus.ready) begin
                nrdy++;
                got = bus.o_data;
            end
        end
        chk("lost_one_ready", 32'(nrdy), 1);
        chk("lost_data", got, 32'hC0DE0003);
        chk("lost_err_keep", 32'(bus.err_req), 1);

        // Mid-frame reset: second word of the frame delivered, then asynchronous reset
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h000000D1;
        tick();
        bus.s_data  = 32'h000000D2;
        tick();
        bus.s_valid = 1'b0;
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        tick();
        chk("mid_ready", 32'(bus.ready), 1);
        chk("mid_data", bus.o_data, 32'h000000D1);
        #3 rst = 1'b1;
        #1;
        chk_reset_outs("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        nrdy = 0;
        repeat (4) begin
            tick();
            nrdy += int'(bus.ready);
        end
        chk("mid_nostart_ready", 32'(nrdy), 0);
        chk("mid_nostart_busy", 32'(bus.busy), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.request = 1'b1;
        tick();
        bus.request = 1'b0;
        nrdy = 0;
        repeat (4) begin
            tick();
            nrdy += int'(bus.ready);
        end
        chk("mid_flushed_ready", 32'(nrdy), 0);
        chk("mid_flushed_busy", 32'(bus.busy), 1);
        chk("mid_flushed_err", 32'(bus.err_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
